regfile_rw_seq: RTL and testbench
=================================

// Module: regfile_rw_seq
// PURPOSE
//  Initiator-side sequencer for the 8x16 register file's read/write port pair.
//  On a start pulse it reads a source register, optionally transforms the value, and writes a destination register.
//  SWAP reads both registers and writes each into the other.
//  Sits between a controller FSM and the register file: drives readnum/writenum/write/data_in and consumes data_out.
// PARAMETERS
//  DATA_W  16  register width; must match the register file data width
//  ADDR_W  3   register index width (2**ADDR_W registers)
// PORTS
//  clk        in   1       rising-edge clock, shared with the register file
//  reset      in   1       synchronous, active-high reset
//  start      in   1       request; sampled only in IDLE
//  src        in   ADDR_W  source register index, captured with start
//  dst        in   ADDR_W  destination register index, captured with start
//  op         in   2       00 MOV, 01 LSL1, 10 LSR1, 11 SWAP; captured with start
//  busy       out  1       1 in every state except IDLE
//  done       out  1       one-cycle pulse in DONE state
//  rf_readnum out  ADDR_W  to register file readnum
//  rf_rdata   in   DATA_W  from register file data_out; combinational on rf_readnum
//  rf_writenum out ADDR_W  to register file writenum
//  rf_write   out  1       to register file write enable
//  rf_wdata   out  DATA_W  to register file data_in
//  result     out  DATA_W  last value written to dst; held until the next op's WR_A
// BEHAVIOUR
//  One clock, clk. Reset is synchronous and active-high on port reset.
//  Reset: state=IDLE; busy=0, done=0, rf_write=0; rf_readnum=0, rf_writenum=0, rf_wdata=0; result=0; internal tmp_a=tmp_b=0.
//  Reset has priority over everything, including mid-operation.
//    - Any write not yet clocked is abandoned.
//    - rf_write is 0 in the cycle after the reset edge.
//  All outputs decode from registered state plus captured fields; no combinational path from start to rf_*.
//  States: IDLE, RD_A, RD_B, WR_A, WR_B, DONE. Encoding is free.
//  IDLE:
//    - start=1 at an edge: capture src/dst/op, go to RD_A.
//    - start=0: stay in IDLE.
//  RD_A:
//    - rf_readnum=src; tmp_a <= rf_rdata at the exit edge.
//    - Next state RD_B if op=SWAP, else WR_A.
//  RD_B:
//    - rf_readnum=dst; tmp_b <= rf_rdata at the exit edge.
//    - Next state WR_A.
//  WR_A:
//    - rf_write=1, rf_writenum=dst, rf_wdata=f(tmp_a); result <= rf_wdata.
//    - Next state WR_B if SWAP, else DONE.
//  WR_B:
//    - rf_write=1, rf_writenum=src, rf_wdata=tmp_b.
//    - Next state DONE.
//  DONE: done=1; next state IDLE. start is ignored in DONE.
//  f(x) by op:
//    - MOV: x.
//    - LSL1: {x[DATA_W-2:0],1'b0}.
//    - LSR1: {1'b0,x[DATA_W-1:1]}. Logical shift, MSB filled with 0, shifted-out bit discarded.
//    - SWAP: x.
//  rf_write=0 in IDLE, RD_A, RD_B, DONE. rf_readnum/rf_writenum/rf_wdata are 0 in states that do not use them.
//  Latency with start high in cycle 0 (IDLE):
//    - MOV/LSL1/LSR1: WR_A in cycle 2, done=1 in cycle 3; next start accepted in cycle 4.
//    - SWAP: WR_A cycle 3, WR_B cycle 4, done cycle 5.
//  start while busy=1 is ignored, not queued; input changes during an operation have no effect.
//  src==dst:
//    - MOV leaves the value unchanged.
//    - SWAP performs both writes and leaves the value unchanged.
//    - LSL1/LSR1 shift the register in place.
//  RD_B reads dst before either write, so SWAP uses pre-operation values for both registers.
// TESTING
//  Preload R3=16'h1234. start, op=MOV, src=3, dst=5 -> rf_write high only in cycle 2 with writenum=5, wdata=16'h1234; done in cycle 3; R5=16'h1234.
//  R1=16'h8001. op=LSL1 src=1 dst=2 -> R2=16'h0002. op=LSR1 src=1 dst=2 -> R2=16'h4000.
//  R0=16'hAAAA, R7=16'h5555. op=SWAP src=0 dst=7 -> R7=16'hAAAA written cycle 3, R0=16'h5555 written cycle 4, done cycle 5.
//  op=SWAP src=dst=4 with R4=16'hBEEF -> two writes of 16'hBEEF to R4, R4 unchanged, done cycle 5.
//  start re-pulsed in cycles 1-3 of a MOV -> ignored; exactly one write occurs. Back-to-back start in cycle 4 is accepted.
//  reset asserted at the edge ending RD_A of a MOV -> no write ever issued; all outputs at reset values; dst unchanged.

Source files
------------

// File: rtl/regfile_rw_seq_if.sv
// Bus bundle between the controller/register file and the register-file sequencer.
// The controller and register file use master; the sequencer uses slave.
interface regfile_rw_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              start;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [1:0]        op;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rf_readnum;
  logic [DATA_W-1:0] rf_rdata;
  logic [ADDR_W-1:0] rf_writenum;
  logic              rf_write;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] result;

  modport master (
    output start, src, dst, op, rf_rdata,
    input  busy, done, rf_readnum, rf_writenum, rf_write, rf_wdata, result
  );

  modport slave (
    input  start, src, dst, op, rf_rdata,
    output busy, done, rf_readnum, rf_writenum, rf_write, rf_wdata, result
  );
endinterface

// File: rtl/regfile_rw_seq.sv
// Register-file sequencer: read src, optionally shift, write dst; SWAP exchanges two registers.
// All register-file controls are decoded from the registered state and captured request fields.
module regfile_rw_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  regfile_rw_seq_if.slave  bus
);

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_LSL1 = 2'b01;
  localparam logic [1:0] OP_LSR1 = 2'b10;
  localparam logic [1:0] OP_SWAP = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    DONE = 3'd5
  } state_e;

  state_e            state, state_n;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] tmp_a, tmp_b;
  logic [DATA_W-1:0] result_q;

  logic              busy_c, done_c, write_c;
  logic [ADDR_W-1:0] readnum_c, writenum_c;
  logic [DATA_W-1:0] wdata_c;

  function automatic logic [DATA_W-1:0] xform(input logic [1:0] o, input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    case (o)
      OP_LSL1: y = {x[DATA_W-2:0], 1'b0};
      OP_LSR1: y = {1'b0, x[DATA_W-1:1]};
      default: y = x;  // MOV and SWAP pass the value through
    endcase
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      op_q     <= OP_MOV;
      tmp_a    <= '0;
      tmp_b    <= '0;
      result_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start) begin
          src_q <= bus.src;
          dst_q <= bus.dst;
          op_q  <= bus.op;
        end
        RD_A: tmp_a    <= bus.rf_rdata;
        RD_B: tmp_b    <= bus.rf_rdata;
        WR_A: result_q <= wdata_c;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n    = state;
    busy_c     = 1'b1;
    done_c     = 1'b0;
    write_c    = 1'b0;
    readnum_c  = '0;
    writenum_c = '0;
    wdata_c    = '0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_n = RD_A;
      end
      RD_A: begin
        readnum_c = src_q;
        state_n   = (op_q == OP_SWAP) ? RD_B : WR_A;
      end
      RD_B: begin
        // dst is read before either write so SWAP sees pre-operation values
        readnum_c = dst_q;
        state_n   = WR_A;
      end
      WR_A: begin
        write_c    = 1'b1;
        writenum_c = dst_q;
        wdata_c    = xform(op_q, tmp_a);
        state_n    = (op_q == OP_SWAP) ? WR_B : DONE;
      end
      WR_B: begin
        write_c    = 1'b1;
        writenum_c = src_q;
        wdata_c    = tmp_b;
        state_n    = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.rf_write    = write_c;
  assign bus.rf_readnum  = readnum_c;
  assign bus.rf_writenum = writenum_c;
  assign bus.rf_wdata    = wdata_c;
  assign bus.result      = result_q;

endmodule

// File: tb/tb_regfile_rw_seq.sv
// Bench for regfile_rw_seq: an 8x16 register file model plus a scoreboard of expected writes.
module tb_regfile_rw_seq;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam logic [1:0] MOV = 2'b00, LSL1 = 2'b01, LSR1 = 2'b10, SWAP = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  logic [DATA_W-1:0] rf [8];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  wr_t               exp_q[$];

  regfile_rw_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_rw_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write at the rising edge
  assign bus.rf_rdata = rf[bus.rf_readnum];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (bus.rf_write === 1'b1) rf[bus.rf_writenum] <= bus.rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every write seen on the port must be the next one the bench expects
  always @(negedge clk) begin
    if (bus.rf_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {29'd0, bus.rf_writenum}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {29'd0, bus.rf_writenum}, {29'd0, e.addr});
        chk("wr_data", {16'd0, bus.rf_wdata}, {16'd0, e.data});
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] model_f(input logic [1:0] o, input logic [DATA_W-1:0] x);
    if (o == LSL1) return x << 1;
    if (o == LSR1) return x >> 1;
    return x;
  endfunction

  // Called in an IDLE cycle; returns in the first IDLE cycle after done.
  task automatic do_op(input logic [1:0] o, input logic [ADDR_W-1:0] s,
                       input logic [ADDR_W-1:0] d, input bit repulse);
    logic [DATA_W-1:0] a, b, fa;
    wr_t w;
    a  = rf[s];
    b  = rf[d];
    fa = model_f(o, a);
    w.addr = d; w.data = fa; exp_q.push_back(w);
    if (o == SWAP) begin
      w.addr = s; w.data = b; exp_q.push_back(w);
    end
    chk("c0_busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1; bus.op = o; bus.src = s; bus.dst = d;
    step();
    if (repulse) begin
      bus.op = SWAP; bus.src = 3'd7; bus.dst = 3'd0;
    end else begin
      bus.start = 1'b0;
    end
    chk("c1_busy", {31'd0, bus.busy}, 32'd1);
    chk("c1_write", {31'd0, bus.rf_write}, 32'd0);
    chk("c1_readnum", {29'd0, bus.rf_readnum}, {29'd0, s});
    step();
    if (o == SWAP) begin
      chk("c2_readnum", {29'd0, bus.rf_readnum}, {29'd0, d});
      chk("c2_write", {31'd0, bus.rf_write}, 32'd0);
      step();
    end
    chk("wra_write", {31'd0, bus.rf_write}, 32'd1);
    chk("wra_writenum", {29'd0, bus.rf_writenum}, {29'd0, d});
    chk("wra_done", {31'd0, bus.done}, 32'd0);
    step();
    if (o == SWAP) begin
      chk("wrb_write", {31'd0, bus.rf_write}, 32'd1);
      chk("wrb_writenum", {29'd0, bus.rf_writenum}, {29'd0, s});
      step();
    end
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
    chk("done_write", {31'd0, bus.rf_write}, 32'd0);
    chk("result", {16'd0, bus.result}, {16'd0, fa});
    step();
    bus.start = 1'b0;
    chk("idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_done", {31'd0, bus.done}, 32'd0);
    if (o == SWAP) begin
      chk("swap_rd", {16'd0, rf[d]}, {16'd0, (s == d) ? b : a});
      chk("swap_rs", {16'd0, rf[s]}, {16'd0, b});
    end else begin
      chk("rf_dst", {16'd0, rf[d]}, {16'd0, fa});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.op = MOV;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_write", {31'd0, bus.rf_write}, 32'd0);
    chk("rst_readnum", {29'd0, bus.rf_readnum}, 32'd0);
    chk("rst_writenum", {29'd0, bus.rf_writenum}, 32'd0);
    chk("rst_wdata", {16'd0, bus.rf_wdata}, 32'd0);
    chk("rst_result", {16'd0, bus.result}, 32'd0);
    reset = 1'b0;

    preload(3'd3, 16'h1234);
    preload(3'd1, 16'h8001);
    preload(3'd0, 16'hAAAA);
    preload(3'd7, 16'h5555);
    preload(3'd4, 16'hBEEF);
    preload(3'd6, 16'h0F0F);
    preload(3'd2, 16'hFFFF);

    do_op(MOV, 3'd3, 3'd5, 1'b0);
    chk("mov_r5", {16'd0, rf[5]}, 32'h1234);
    do_op(LSL1, 3'd1, 3'd2, 1'b0);
    chk("lsl_r2", {16'd0, rf[2]}, 32'h0002);
    do_op(LSR1, 3'd1, 3'd2, 1'b0);
    chk("lsr_r2", {16'd0, rf[2]}, 32'h4000);
    do_op(SWAP, 3'd0, 3'd7, 1'b0);
    chk("swap_r7", {16'd0, rf[7]}, 32'hAAAA);
    chk("swap_r0", {16'd0, rf[0]}, 32'h5555);
    do_op(SWAP, 3'd4, 3'd4, 1'b0);
    chk("swap_self_r4", {16'd0, rf[4]}, 32'hBEEF);
    do_op(LSL1, 3'd1, 3'd1, 1'b0);
    chk("lsl_inplace_r1", {16'd0, rf[1]}, 32'h0002);
    do_op(MOV, 3'd5, 3'd5, 1'b0);
    chk("mov_self_r5", {16'd0, rf[5]}, 32'h1234);

    // Re-pulsed start during the op, then an immediate back-to-back op
    do_op(MOV, 3'd3, 3'd2, 1'b1);
    chk("repulse_r2", {16'd0, rf[2]}, 32'h1234);
    do_op(LSR1, 3'd4, 3'd3, 1'b0);
    chk("b2b_r3", {16'd0, rf[3]}, 32'h5F77);

    // Reset at the edge ending RD_A abandons the write
    bus.start = 1'b1; bus.op = MOV; bus.src = 3'd3; bus.dst = 3'd6;
    step();
    bus.start = 1'b0;
    reset = 1'b1;
    step();
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_write", {31'd0, bus.rf_write}, 32'd0);
    chk("mid_rst_readnum", {29'd0, bus.rf_readnum}, 32'd0);
    chk("mid_rst_writenum", {29'd0, bus.rf_writenum}, 32'd0);
    chk("mid_rst_wdata", {16'd0, bus.rf_wdata}, 32'd0);
    chk("mid_rst_result", {16'd0, bus.result}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_r6", {16'd0, rf[6]}, 32'h0F0F);
    chk("mid_rst_idle", {31'd0, bus.busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
